ram_dual_rmw: RTL and testbench
===============================

# ram_dual_rmw

Parametrised dual-port on-chip RAM for the two bus masters of the SoC, i.e. instruction fetch on port 0 and load/store on port 1. Each port has its own byte-lane width and optional fractional (byte-enable) write support, done as a two-cycle read-modify-write. It adds three things over the previous generation:
- an optional write-completion response,
- a cross-port same-word hazard guard, so one port's merge cannot overwrite the other port's write,
- asynchronous active-low reset.

## Interface
Parameters:
- DAT_WIDTH, 32, word width in bits; a multiple of 8, range 16..128; NB = DAT_WIDTH/8 byte lanes, OB = log2(NB)
- MEM_SIZE, 1024, depth in words; AW = log2(MEM_SIZE)
- MEM_INIT, "YES", preload the array with $readmemh(MEM_DATA)
- MEM_DATA, "data.hex", preload file
- P0_FRAC / P1_FRAC, "NO", enables byte-enable read-modify-write and lane shifting on that port
- P0_WRESP / P1_WRESP, "NO", when "YES" the port pulses resp on write completion

Ports (x = 0, 1):
- clk_i, in, 1, clock; all logic is on the rising edge
- rst_n_i, in, 1, asynchronous active-low reset
- busx_req_i, in, 1, request
- busx_we_i, in, 1, 1 = write
- busx_addr_bi, in, 32, byte address; word index = addr[OB+AW-1:OB], lane offset = addr[OB-1:0]
- busx_be_bi, in, NB, byte enables, relative to the lane offset
- busx_wdata_bi, in, DAT_WIDTH, write data, relative to the lane offset
- busx_ack_o, out, 1, request accepted this cycle (combinational)
- busx_resp_o, out, 1, single-cycle pulse: read data valid, or write done
- busx_rdata_bo, out, DAT_WIDTH, read data, shifted right by offset*8 when FRAC = "YES"

## Operation
- Array: MEM_SIZE x DAT_WIDTH, true dual port, registered read, read-first on each port. Contents are not affected by reset.
- Per-port FSM with two states:
  - IDLE → WB: ack of a write with FRAC = "YES" and be ≠ all-ones (a partial write). In that cycle the array write is suppressed and the array read of that word is issued.
  - WB → IDLE: unconditional, after one cycle. In WB the port writes the merged word to the buffered word address.
  - Merge: start from rdata; for each k with be_buf[k] = 1 and offset + k < NB, lane (offset + k) takes wdata_buf byte k. Lanes that fall beyond NB are dropped.
- FRAC = "NO": be is ignored, every write is a full-word write, and offset is ignored on both read and write.
- FRAC = "YES" with be all-ones: single-cycle full write, data unshifted (the offset is meant to be 0).
- On every ack the port buffers addr, be and wdata.
- busx_ack_o = req & (state = IDLE) & !stall_x, where:
  - stall_0 = port 1 is in WB on the same word index;
  - stall_1 = port 0 is in WB on the same word, or port 0 is acked this cycle with a write of any kind to the same word. Port 0 wins ties.
- Port 1 read of a word that port 0 writes in the same cycle returns the old data (read-first). This is legal and is not stalled.
- Reset asserted: every state goes to IDLE; resp and all buffers clear to 0; a pending WB is discarded and the word keeps its old value.

## Timing
- Read: ack in cycle N; resp = 1 with rdata valid in N+1; rdata is held until the next read is acked on that port.
- Full write: ack in N; array updated at the edge ending N; resp in N+1 if WRESP = "YES".
- Partial write: ack in N, ack = 0 in N+1 (WB), array updated at the edge ending N+1. resp in N+2 if WRESP = "YES". The earliest next ack is N+2.
- Back-to-back full writes or reads: one per cycle, no bubbles.
- Reset values: ack follows its equation (0 whenever req = 0); resp_o = 0; rdata_bo = 0 until the first read.
- A WB cannot be aborted by req = 0; it completes regardless of bus activity.

## Test plan
1. DAT_WIDTH = 32: write 0xDEADBEEF to 0x10 on port 0, then read 0x10 on port 1 → port 1 resp in the cycle after its ack, rdata = 0xDEADBEEF.
2. P1_FRAC = "YES": word 0x10 = 0x11223344; write addr 0x11, be = 0b0001, wdata = 0xAA → ack low for one cycle; reading 0x10 returns 0x1122AA44; reading 0x12 returns 0x00001122.
3. Same cycle: port 0 full write and port 1 partial write to the same word → port 1 ack = 0 for that cycle and accepted next cycle; the final word contains port 0's data with port 1's byte merged on top.
4. P0_WRESP = "YES", P0_FRAC = "YES": partial write acked in cycle N → resp_0 = 1 in exactly N+2 and 0 otherwise; a full write acked in cycle M → resp_0 = 1 in M+1.
5. DAT_WIDTH = 64, offset 6, be = 0xFF → only lanes 6..7 change; lanes 0..5 unchanged.
6. Assert rst_n_i asynchronously in the middle of a WB → resp and state clear immediately; the word keeps its pre-write value; the first read after reset returns that value.

Source files
------------

// File: rtl/ram_dual_rmw.sv
// Dual-port word RAM with per-port byte-enable read-modify-write,
// optional write-completion pulse and a cross-port same-word hazard guard.
module ram_dual_rmw #(
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned MEM_SIZE  = 1024,
  parameter string       MEM_INIT  = "YES",
  parameter string       MEM_DATA  = "data.hex",
  parameter string       P0_FRAC   = "NO",
  parameter string       P1_FRAC   = "NO",
  parameter string       P0_WRESP  = "NO",
  parameter string       P1_WRESP  = "NO"
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   bus0_req_i,
  input  logic                   bus0_we_i,
  input  logic [31:0]            bus0_addr_bi,
  input  logic [DAT_WIDTH/8-1:0] bus0_be_bi,
  input  logic [DAT_WIDTH-1:0]   bus0_wdata_bi,
  output logic                   bus0_ack_o,
  output logic                   bus0_resp_o,
  output logic [DAT_WIDTH-1:0]   bus0_rdata_bo,
  input  logic                   bus1_req_i,
  input  logic                   bus1_we_i,
  input  logic [31:0]            bus1_addr_bi,
  input  logic [DAT_WIDTH/8-1:0] bus1_be_bi,
  input  logic [DAT_WIDTH-1:0]   bus1_wdata_bi,
  output logic                   bus1_ack_o,
  output logic                   bus1_resp_o,
  output logic [DAT_WIDTH-1:0]   bus1_rdata_bo
);

  localparam int unsigned NB = DAT_WIDTH / 8;
  localparam int unsigned OB = $clog2(NB);
  localparam int unsigned AW = $clog2(MEM_SIZE);
  localparam logic [1:0]  FRAC  = {P1_FRAC == "YES", P0_FRAC == "YES"};
  localparam logic [1:0]  WRESP = {P1_WRESP == "YES", P0_WRESP == "YES"};

  typedef enum logic {ST_IDLE, ST_WB} state_e;

  logic [DAT_WIDTH-1:0] mem_q [MEM_SIZE];

  // Port inputs gathered into per-port arrays
  logic [1:0]           req, we;
  logic [31:0]          addr  [2];
  logic [NB-1:0]        be    [2];
  logic [DAT_WIDTH-1:0] wdata [2];

  assign req      = {bus1_req_i, bus0_req_i};
  assign we       = {bus1_we_i, bus0_we_i};
  assign addr[0]  = bus0_addr_bi;
  assign addr[1]  = bus1_addr_bi;
  assign be[0]    = bus0_be_bi;
  assign be[1]    = bus1_be_bi;
  assign wdata[0] = bus0_wdata_bi;
  assign wdata[1] = bus1_wdata_bi;

  logic unused_addr;
  assign unused_addr = ^{bus0_addr_bi[31:OB+AW], bus1_addr_bi[31:OB+AW]};

  state_e               state_q [2];
  state_e               state_d [2];
  logic [OB+AW-1:0]     addr_q  [2];
  logic [NB-1:0]        be_q    [2];
  logic [DAT_WIDTH-1:0] wdata_q [2];
  logic [DAT_WIDTH-1:0] rdata_q [2];
  logic [DAT_WIDTH-1:0] rmw_q   [2];
  logic [1:0]           resp_q;

  logic [AW-1:0]        widx    [2];
  logic [OB-1:0]        off     [2];
  logic [AW-1:0]        bidx    [2];
  logic [OB-1:0]        boff    [2];
  logic [1:0]           partial;
  logic                 ack0, ack1, stall0, stall1;
  logic [1:0]           ack;
  logic [DAT_WIDTH-1:0] merged  [2];
  logic [1:0]           mwe;
  logic [AW-1:0]        mwaddr  [2];
  logic [DAT_WIDTH-1:0] mwdata  [2];

  // Decode live and buffered addresses; offsets are forced to 0 on non-fractional ports
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      widx[p]    = addr[p][OB+AW-1:OB];
      off[p]     = FRAC[p] ? addr[p][OB-1:0] : '0;
      bidx[p]    = addr_q[p][OB+AW-1:OB];
      boff[p]    = FRAC[p] ? addr_q[p][OB-1:0] : '0;
      partial[p] = FRAC[p] && we[p] && (be[p] != '1);
    end
  end

  // Accept logic with same-word hazard guard; port 0 wins ties.
  // A port 1 read alongside a port 0 write to the same word is let through
  // (read-first returns the old word); only port 1 writes are held off.
  always_comb begin
    stall0 = (state_q[1] == ST_WB) && (bidx[1] == widx[0]);
    ack0   = req[0] && (state_q[0] == ST_IDLE) && !stall0;
    stall1 = ((state_q[0] == ST_WB) && (bidx[0] == widx[1])) ||
             (ack0 && we[0] && we[1] && (widx[0] == widx[1]));
    ack1   = req[1] && (state_q[1] == ST_IDLE) && !stall1;
  end

  assign ack = {ack1, ack0};

  // Merge buffered bytes onto the word read during the accept cycle; lanes past NB drop
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      merged[p] = rmw_q[p];
      for (int unsigned k = 0; k < NB; k++) begin
        if (be_q[p][k] && (32'(boff[p]) + k < NB)) begin
          merged[p][(32'(boff[p]) + k)*8 +: 8] = wdata_q[p][k*8 +: 8];
        end
      end
    end
  end

  // Next state and array write controls per port
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      mwe[p]     = 1'b0;
      mwaddr[p]  = widx[p];
      mwdata[p]  = wdata[p];
      case (state_q[p])
        ST_IDLE: begin
          if (ack[p] && partial[p]) begin
            state_d[p] = ST_WB;
          end else if (ack[p] && we[p]) begin
            mwe[p] = 1'b1;
          end
        end
        ST_WB: begin
          state_d[p] = ST_IDLE;
          mwe[p]     = 1'b1;
          mwaddr[p]  = bidx[p];
          mwdata[p]  = merged[p];
        end
        default: state_d[p] = ST_IDLE;
      endcase
    end
  end

  // Port state, request buffers, response pulse and read data registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned p = 0; p < 2; p++) begin
        state_q[p] <= ST_IDLE;
        addr_q[p]  <= '0;
        be_q[p]    <= '0;
        wdata_q[p] <= '0;
        rdata_q[p] <= '0;
        rmw_q[p]   <= '0;
      end
      resp_q <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        resp_q[p]  <= (ack[p] && !we[p]) ||
                      (WRESP[p] && ((ack[p] && we[p] && !partial[p]) ||
                                    (state_q[p] == ST_WB)));
        if (ack[p]) begin
          addr_q[p]  <= addr[p][OB+AW-1:0];
          be_q[p]    <= be[p];
          wdata_q[p] <= wdata[p];
        end
        if (ack[p] && !we[p]) begin
          rdata_q[p] <= mem_q[widx[p]] >> {off[p], 3'b000};
        end
        if (ack[p] && partial[p]) begin
          rmw_q[p] <= mem_q[widx[p]];
        end
      end
    end
  end

  // Array write ports; contents are not reset
  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (mwe[p]) begin
        mem_q[mwaddr[p]] <= mwdata[p];
      end
    end
  end

  assign bus0_ack_o    = ack0;
  assign bus1_ack_o    = ack1;
  assign bus0_resp_o   = resp_q[0];
  assign bus1_resp_o   = resp_q[1];
  assign bus0_rdata_bo = rdata_q[0];
  assign bus1_rdata_bo = rdata_q[1];

endmodule

// File: tb/tb_ram_dual_rmw.sv
// Scoreboard bench for ram_dual_rmw: a 32-bit instance exercising both ports
// and hazards, plus a 64-bit instance for wide-lane merging and non-fractional port behaviour.
module tb_ram_dual_rmw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Main 32-bit instance: P0 fractional + write response, P1 fractional, no write response
  localparam logic [1:0] FRAC_P  = 2'b11;
  localparam logic [1:0] WRESP_P = 2'b01;

  logic [1:0]  req, we, ack, resp;
  logic [31:0] addr  [2];
  logic [3:0]  be    [2];
  logic [31:0] wdata [2];
  logic [31:0] rd0, rd1;

  ram_dual_rmw #(
    .DAT_WIDTH(32), .MEM_SIZE(256), .MEM_INIT("NO"), .MEM_DATA("data.hex"),
    .P0_FRAC("YES"), .P1_FRAC("YES"), .P0_WRESP("YES"), .P1_WRESP("NO")
  ) u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .bus0_req_i(req[0]), .bus0_we_i(we[0]), .bus0_addr_bi(addr[0]), .bus0_be_bi(be[0]),
    .bus0_wdata_bi(wdata[0]), .bus0_ack_o(ack[0]), .bus0_resp_o(resp[0]), .bus0_rdata_bo(rd0),
    .bus1_req_i(req[1]), .bus1_we_i(we[1]), .bus1_addr_bi(addr[1]), .bus1_be_bi(be[1]),
    .bus1_wdata_bi(wdata[1]), .bus1_ack_o(ack[1]), .bus1_resp_o(resp[1]), .bus1_rdata_bo(rd1)
  );

  // Wide 64-bit instance: P0 fractional, P1 plain full-word
  logic [1:0]  wreq, wwe, wack, wresp;
  logic [31:0] waddr [2];
  logic [7:0]  wbe   [2];
  logic [63:0] wwd   [2];
  logic [63:0] wrd0, wrd1;

  ram_dual_rmw #(
    .DAT_WIDTH(64), .MEM_SIZE(64), .MEM_INIT("NO"), .MEM_DATA("data.hex"),
    .P0_FRAC("YES"), .P1_FRAC("NO"), .P0_WRESP("NO"), .P1_WRESP("NO")
  ) u_wide (
    .clk_i(clk), .rst_n_i(rst_n),
    .bus0_req_i(wreq[0]), .bus0_we_i(wwe[0]), .bus0_addr_bi(waddr[0]), .bus0_be_bi(wbe[0]),
    .bus0_wdata_bi(wwd[0]), .bus0_ack_o(wack[0]), .bus0_resp_o(wresp[0]), .bus0_rdata_bo(wrd0),
    .bus1_req_i(wreq[1]), .bus1_we_i(wwe[1]), .bus1_addr_bi(waddr[1]), .bus1_be_bi(wbe[1]),
    .bus1_wdata_bi(wwd[1]), .bus1_ack_o(wack[1]), .bus1_resp_o(wresp[1]), .bus1_rdata_bo(wrd1)
  );

  typedef struct {
    int          due;
    bit          isrd;
    logic [31:0] data;
  } sb_e;

  sb_e sbq [2][$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_of(input int p);
    return (p == 0) ? rd0 : rd1;
  endfunction

  // Drive one request on the 32-bit instance, wait (bounded) for ack, queue its expected response
  task automatic do_op(input int p, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] exp, output int ack_cyc);
    sb_e e;
    bit  part;
    req[p] = 1'b1; we[p] = w; addr[p] = a; be[p] = b; wdata[p] = d;
    ack_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack[p]) begin
        ack_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (ack_cyc < 0) begin
      chk($sformatf("p%0d_ack_timeout", p), 64'(ack[p]), 64'd1);
    end else begin
      part = FRAC_P[p] && w && (b != 4'hF);
      if (!w) begin
        e.due = ack_cyc + 1; e.isrd = 1'b1; e.data = exp;
        sbq[p].push_back(e);
      end else if (WRESP_P[p]) begin
        e.due = ack_cyc + (part ? 2 : 1); e.isrd = 1'b0; e.data = '0;
        sbq[p].push_back(e);
      end
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic mon(input int p);
    sb_e e;
    while (sbq[p].size() > 0 && sbq[p][0].due < cyc) begin
      chk($sformatf("p%0d_resp_missing_due", p), 64'(sbq[p][0].due), 64'(cyc));
      void'(sbq[p].pop_front());
    end
    if (sbq[p].size() > 0 && sbq[p][0].due == cyc) begin
      e = sbq[p].pop_front();
      chk($sformatf("p%0d_resp", p), 64'(resp[p]), 64'd1);
      if (e.isrd) chk($sformatf("p%0d_rdata", p), 64'(rd_of(p)), 64'(e.data));
    end else if (resp[p]) begin
      chk($sformatf("p%0d_resp_spurious", p), 64'(resp[p]), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // One request on the 64-bit instance; reads are checked directly the following cycle
  task automatic w_op(input int p, input bit w, input logic [31:0] a, input logic [7:0] b,
                      input logic [63:0] d, input logic [63:0] exp);
    bit got_ack = 1'b0;
    wreq[p] = 1'b1; wwe[p] = w; waddr[p] = a; wbe[p] = b; wwd[p] = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wack[p]) begin
        got_ack = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got_ack) chk($sformatf("w%0d_ack_timeout", p), 64'(wack[p]), 64'd1);
    @(posedge clk); #1;
    wreq[p] = 1'b0;
    if (!w && got_ack) begin
      @(negedge clk);
      chk($sformatf("w%0d_resp", p), 64'(wresp[p]), 64'd1);
      chk($sformatf("w%0d_rdata", p), (p == 0) ? wrd0 : wrd1, exp);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int a0, a1, t;
    rst_n = 1'b0;
    req = '0; we = '0; wreq = '0; wwe = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; be[i] = '0; wdata[i] = '0;
      waddr[i] = '0; wbe[i] = '0; wwd[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ack0", 64'(ack[0]), 64'd0);
    chk("rst_ack1", 64'(ack[1]), 64'd0);
    chk("rst_resp", 64'(resp), 64'd0);
    chk("rst_rdata0", 64'(rd0), 64'd0);
    chk("rst_rdata1", 64'(rd1), 64'd0);
    chk("rst_wide_rdata0", wrd0, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full write on port 0, read back on port 1
    do_op(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, '0, a0);
    do_op(1, 1'b0, 32'h10, 4'hF, '0, 32'hDEADBEEF, a1);

    // Partial write on port 1 and shifted reads
    do_op(1, 1'b1, 32'h10, 4'hF, 32'h11223344, '0, a1);
    do_op(1, 1'b1, 32'h11, 4'b0001, 32'h000000AA, '0, a1);
    do_op(1, 1'b0, 32'h10, 4'hF, '0, 32'h1122AA44, t);
    chk("p1_next_ack_after_partial", 64'(t), 64'(a1 + 2));
    do_op(1, 1'b0, 32'h12, 4'hF, '0, 32'h00001122, t);
    // Offset 3 with two enabled bytes: upper byte falls off the word
    do_op(1, 1'b1, 32'h13, 4'b0011, 32'h0000BBCC, '0, a1);
    do_op(0, 1'b0, 32'h10, 4'hF, '0, 32'hCC22AA44, t);
    do_op(0, 1'b0, 32'h13, 4'hF, '0, 32'h000000CC, t);

    // Port 0 write responses: full then partial
    do_op(0, 1'b1, 32'h20, 4'hF, 32'h01234567, '0, a0);
    do_op(0, 1'b1, 32'h21, 4'b0010, 32'h00007700, '0, a0);
    do_op(1, 1'b0, 32'h20, 4'hF, '0, 32'h01774567, t);

    // Same-cycle full write on port 0 and partial on port 1 to one word
    do_op(0, 1'b1, 32'h30, 4'hF, 32'h00000000, '0, a0);
    fork
      do_op(0, 1'b1, 32'h30, 4'hF, 32'hA5A5A5A5, '0, a0);
      do_op(1, 1'b1, 32'h30, 4'b0100, 32'h00CC0000, '0, a1);
    join
    chk("p1_stalled_by_p0_write", 64'(a1), 64'(a0 + 1));
    do_op(1, 1'b0, 32'h30, 4'hF, '0, 32'hA5CCA5A5, t);

    // Port 0 request held off while port 1 merges the same word
    do_op(1, 1'b1, 32'h40, 4'hF, 32'h0BADF00D, '0, a1);
    fork
      do_op(1, 1'b1, 32'h42, 4'b0001, 32'h0000005A, '0, a1);
      begin
        @(posedge clk); #1;
        do_op(0, 1'b0, 32'h40, 4'hF, '0, 32'h0B5AF00D, a0);
      end
    join
    chk("p0_stalled_by_p1_wb", 64'(a0), 64'(a1 + 2));

    // Port 1 read alongside port 0 write of the same word returns old data
    do_op(0, 1'b1, 32'h50, 4'hF, 32'h01020304, '0, a0);
    fork
      do_op(0, 1'b1, 32'h50, 4'hF, 32'h55667788, '0, a0);
      do_op(1, 1'b0, 32'h50, 4'hF, '0, 32'h01020304, a1);
    join
    chk("p1_read_not_stalled", 64'(a1), 64'(a0));
    do_op(1, 1'b0, 32'h50, 4'hF, '0, 32'h55667788, t);

    // Back-to-back reads and full writes
    do_op(0, 1'b0, 32'h10, 4'hF, '0, 32'hCC22AA44, a0);
    do_op(0, 1'b0, 32'h50, 4'hF, '0, 32'h55667788, t);
    chk("b2b_read", 64'(t), 64'(a0 + 1));
    do_op(1, 1'b1, 32'h60, 4'hF, 32'h11111111, '0, a1);
    do_op(1, 1'b1, 32'h64, 4'hF, 32'h22222222, '0, t);
    chk("b2b_write", 64'(t), 64'(a1 + 1));
    do_op(0, 1'b0, 32'h60, 4'hF, '0, 32'h11111111, t);
    do_op(0, 1'b0, 32'h64, 4'hF, '0, 32'h22222222, t);

    // Async reset in the middle of a write-back on port 0
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h22; be[0] = 4'b0001; wdata[0] = 32'h000000EE;
    @(negedge clk);
    chk("rst_wb_accept", 64'(ack[0]), 64'd1);
    @(posedge clk); #1;
    we[0] = 1'b0; addr[0] = 32'h20; be[0] = 4'hF;
    @(negedge clk);
    chk("rst_wb_busy", 64'(ack[0]), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_idle", 64'(ack[0]), 64'd1);
    chk("rst_async_resp", 64'(resp), 64'd0);
    chk("rst_async_rdata0", 64'(rd0), 64'd0);
    chk("rst_async_rdata1", 64'(rd1), 64'd0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(0, 1'b0, 32'h20, 4'hF, '0, 32'h01774567, t);

    // 64-bit instance: offset-6 merge with dropped lanes, and the plain port
    w_op(0, 1'b1, 32'h08, 8'hFF, 64'h0011223344556677, '0);
    w_op(0, 1'b1, 32'h0E, 8'h0F, 64'h00000000DDCCBBAA, '0);
    w_op(0, 1'b0, 32'h08, 8'hFF, '0, 64'hBBAA223344556677);
    w_op(0, 1'b0, 32'h0E, 8'hFF, '0, 64'h000000000000BBAA);
    w_op(1, 1'b1, 32'h13, 8'h01, 64'h1122334455667788, '0);
    w_op(1, 1'b0, 32'h15, 8'h00, '0, 64'h1122334455667788);
    w_op(1, 1'b0, 32'h0E, 8'hFF, '0, 64'hBBAA223344556677);

    repeat (4) @(negedge clk);
    chk("sb_p0_drained", 64'(sbq[0].size()), 64'd0);
    chk("sb_p1_drained", 64'(sbq[1].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
